// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester register-file writeback arbiter
// Round-robin between pipeline writeback (A) and a long-latency unit (B), one-cycle registered write port.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arb_en,
  input  logic                     a_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_dest,
  input  logic [DATA_WIDTH-1:0]    a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDRESS_WIDTH-1:0] b_dest,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     b_ready,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic [CNT_WIDTH-1:0]     conflict_cnt
);

  logic                     last_b_q;
  logic                     wrt_en_q;
  logic [ADDRESS_WIDTH-1:0] wrt_dest_q;
  logic [DATA_WIDTH-1:0]    wrt_data_q;
  logic [CNT_WIDTH-1:0]     cnt_q;

  logic                     accept;
  logic                     contention;
  logic [ADDRESS_WIDTH-1:0] win_dest;
  logic [DATA_WIDTH-1:0]    win_data;

  // Ready is only ever raised for a requester that is valid, so ready alone marks acceptance.
  always_comb begin
    a_ready    = rst & arb_en & a_valid & (~b_valid | last_b_q);
    b_ready    = rst & arb_en & b_valid & (~a_valid | ~last_b_q);
    accept     = a_ready | b_ready;
    contention = arb_en & a_valid & b_valid;
    win_dest   = b_ready ? b_dest : a_dest;
    win_data   = b_ready ? b_data : a_data;
  end

  // last_b resets to 1 so that A wins the first contention after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b_q   <= 1'b1;
      wrt_en_q   <= 1'b0;
      wrt_dest_q <= '0;
      wrt_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      wrt_en_q <= accept && (win_dest != '0);
      if (accept && (win_dest != '0)) begin
        wrt_dest_q <= win_dest;
        wrt_data_q <= win_data;
      end
      if (accept) begin
        last_b_q <= b_ready;
      end
      if (contention && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign rg_wrt_en    = wrt_en_q;
  assign rg_wrt_dest  = wrt_dest_q;
  assign rg_wrt_data  = wrt_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arb_en = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_dest = '0, b_dest = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  logic [15:0] conflict_cnt;
  logic        a_ready4, b_ready4, rg_wrt_en4;
  logic [4:0]  rg_wrt_dest4;
  logic [31:0] rg_wrt_data4;
  logic [3:0]  conflict_cnt4;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .conflict_cnt(conflict_cnt)
  );

  rf_wb_arbiter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready4),
    .rg_wrt_en(rg_wrt_en4), .rg_wrt_dest(rg_wrt_dest4), .rg_wrt_data(rg_wrt_data4),
    .conflict_cnt(conflict_cnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: who was granted last, what the write port should show, how many contentions seen.
  bit          m_last_b;
  bit          m_en;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  int          m_conflicts;
  bit          exp_a, exp_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last_b    = 1'b1;
    m_en        = 1'b0;
    m_dest      = '0;
    m_data      = '0;
    m_conflicts = 0;
  endtask

  function automatic int min_int(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic predict_grant();
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (rst && arb_en) begin
      if (a_valid && b_valid) begin
        if (m_last_b) exp_a = 1'b1;
        else          exp_b = 1'b1;
      end else begin
        exp_a = a_valid;
        exp_b = b_valid;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".en"}, rg_wrt_en, m_en);
    if (m_en) begin
      check({tag, ".dest"}, rg_wrt_dest, m_dest);
      check({tag, ".data"}, rg_wrt_data, m_data);
    end
    check({tag, ".cnt"},  conflict_cnt,  min_int(m_conflicts, 65535));
    check({tag, ".cnt4"}, conflict_cnt4, min_int(m_conflicts, 15));
  endtask

  // One clock: drive inputs on the low phase, check ready, clock, check registered outputs.
  task automatic cycle(input string tag, input bit en, input bit va, input bit vb,
                       input logic [4:0] da, input logic [31:0] ta,
                       input logic [4:0] db, input logic [31:0] tb_d);
    arb_en = en; a_valid = va; b_valid = vb;
    a_dest = da; a_data = ta; b_dest = db; b_data = tb_d;
    #1;
    predict_grant();
    check({tag, ".a_ready"}, a_ready, exp_a);
    check({tag, ".b_ready"}, b_ready, exp_b);
    @(posedge clk);
    if (en && va && vb) m_conflicts++;
    m_en = 1'b0;
    if (exp_a || exp_b) begin
      m_last_b = exp_b;
      if ((exp_b ? db : da) != 0) begin
        m_en   = 1'b1;
        m_dest = exp_b ? db : da;
        m_data = exp_b ? tb_d : ta;
      end
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #2;
    check("reset.en",   rg_wrt_en,    1'b0);
    check("reset.dest", rg_wrt_dest,  5'd0);
    check("reset.data", rg_wrt_data,  32'd0);
    check("reset.cnt",  conflict_cnt, 16'd0);
    arb_en = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("reset.a_ready", a_ready, 1'b0);
    check("reset.b_ready", b_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Contention straight after reset: A, B, A, B.
    for (int i = 0; i < 4; i++)
      cycle("contend", 1'b1, 1'b1, 1'b1, 5'd1 + 5'(i), 32'hA000 + i, 5'd9 + 5'(i), 32'hB000 + i);
    check("contend.total", conflict_cnt, 16'd4);

    cycle("single_a", 1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0);
    check("single_a.dest", rg_wrt_dest, 5'd3);
    cycle("x0_b", 1'b1, 1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 32'h12345678);
    for (int i = 0; i < 3; i++)
      cycle("en_off", 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 5'd5, 32'h55);
    for (int i = 0; i < 20; i++)
      cycle("saturate", 1'b1, 1'b1, 1'b1, 5'(i), $urandom, 5'(31 - i), $urandom);

    for (int i = 0; i < 400; i++) begin
      bit en;
      bit va;
      bit vb;
      logic [4:0] da;
      logic [4:0] db;
      en = ($urandom_range(0, 7) != 0);
      va = $urandom_range(0, 1);
      vb = $urandom_range(0, 1);
      da = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      db = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle("rand", en, va, vb, da, $urandom, db, $urandom);
    end

    // A persistent A must not starve B for more than one cycle.
    cycle("starve0", 1'b1, 1'b1, 1'b0, 5'd2, 32'h2, 5'd6, 32'h6);
    cycle("starve1", 1'b1, 1'b1, 1'b1, 5'd2, 32'h2, 5'd6, 32'h6);
    cycle("starve2", 1'b1, 1'b1, 1'b1, 5'd2, 32'h2, 5'd6, 32'h6);

    // Reset arriving during a grant cycle.
    arb_en = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_dest = 5'd8; b_dest = 5'd9; a_data = 32'h88; b_data = 32'h99;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("midrst.a_ready", a_ready, 1'b0);
    check("midrst.b_ready", b_ready, 1'b0);
    check("midrst.en",   rg_wrt_en,    1'b0);
    check("midrst.dest", rg_wrt_dest,  5'd0);
    check("midrst.data", rg_wrt_data,  32'd0);
    check("midrst.cnt",  conflict_cnt, 16'd0);
    @(posedge clk);
    #1 check("midrst.hold_en", rg_wrt_en, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cycle("post_rst_idle", 1'b1, 1'b0, 1'b0, 5'd8, 32'h88, 5'd9, 32'h99);
    cycle("post_rst_first", 1'b1, 1'b1, 1'b1, 5'd8, 32'h88, 5'd9, 32'h99);
    check("post_rst_first.dest", rg_wrt_dest, 5'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
